// File: rtl/floo_vc_input_port_rx_if.sv
// Link bundle between the upstream VC sender / switch allocator and the VC input port receiver.
// master drives flits and SA pops; slave is the receiving input port.
interface floo_vc_input_port_rx_if #(
    parameter int unsigned NumVC      = 4,
    parameter int unsigned NumVCWidth = (NumVC > 1) ? $clog2(NumVC) : 1,
    parameter int unsigned DataWidth  = 64,
    parameter int unsigned LaWidth    = 3
);
    logic                                 valid;
    logic [NumVCWidth-1:0]                vc_id;
    logic [LaWidth-1:0]                   look_ahead;
    logic [DataWidth-1:0]                 data;
    logic [NumVC-1:0]                     pop;
    logic [NumVC-1:0]                     vc_valid;
    logic [NumVC-1:0][LaWidth-1:0]        vc_look_ahead;
    logic [NumVC-1:0][DataWidth-1:0]      vc_data;
    logic                                 credit_v;
    logic [NumVCWidth-1:0]                credit_id;
    logic                                 err;

    modport master (
        output valid, vc_id, look_ahead, data, pop,
        input  vc_valid, vc_look_ahead, vc_data, credit_v, credit_id, err
    );

    modport slave (
        input  valid, vc_id, look_ahead, data, pop,
        output vc_valid, vc_look_ahead, vc_data, credit_v, credit_id, err
    );
endinterface

// File: rtl/floo_vc_input_port_rx.sv
// VC input port receiver: per-VC FIFOs with look-ahead route, one registered credit per freed slot.
// Optional sticky protocol error flag enabled by defining FLOO_VC_RX_ERR_EN.
module floo_vc_input_port_rx #(
    parameter int unsigned NumVC      = 4,
    parameter int unsigned NumVCWidth = (NumVC > 1) ? $clog2(NumVC) : 1,
    parameter int unsigned VCDepth    = 2,
    parameter int unsigned DataWidth  = 64,
    parameter int unsigned LaWidth    = 3  // width of route_direction_e
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    floo_vc_input_port_rx_if.slave  link
);
    localparam int unsigned CntW   = $clog2(VCDepth + 1);
    localparam int unsigned PtrW   = (VCDepth > 1) ? $clog2(VCDepth) : 1;
    localparam int unsigned EntryW = LaWidth + DataWidth;

    logic [NumVC-1:0]                vc_valid;
    logic [NumVC-1:0]                full;
    logic [NumVC-1:0]                push_v;
    logic [NumVC-1:0]                pop_v;
    logic [NumVC-1:0]                pop_oh;
    logic [NumVCWidth-1:0]           pop_idx;
    logic                            pop_eff;
    logic                            in_range;
    logic [NumVC-1:0][LaWidth-1:0]   head_la;
    logic [NumVC-1:0][DataWidth-1:0] head_data;
    logic                            credit_v_reg;
    logic [NumVCWidth-1:0]           credit_id_reg;

    // When the id field exactly covers NumVC every encoding is legal.
    generate
        if (NumVC == (1 << NumVCWidth)) begin : g_all_ids
            assign in_range = 1'b1;
        end else begin : g_check_id
            assign in_range = (int'(link.vc_id) < NumVC);
        end
    endgenerate

    // Multi-hot pop requests resolve to the lowest requesting VC.
    always_comb begin
        pop_oh  = '0;
        pop_idx = '0;
        for (int v = NumVC - 1; v >= 0; v--) begin
            if (link.pop[v]) begin
                pop_oh  = '0;
                pop_oh[v] = 1'b1;
                pop_idx = NumVCWidth'(v);
            end
        end
    end

    assign pop_v   = pop_oh & vc_valid;
    assign pop_eff = |pop_v;

    generate
        for (genvar gi = 0; gi < NumVC; gi++) begin : g_vc
            logic [EntryW-1:0] mem [VCDepth];
            logic [PtrW-1:0]   wr_ptr_reg;
            logic [PtrW-1:0]   rd_ptr_reg;
            logic [CntW-1:0]   count_reg;

            // A full VC still accepts a flit when its head leaves in the same cycle.
            assign push_v[gi] = link.valid && in_range && (link.vc_id == NumVCWidth'(gi))
                                && (!full[gi] || pop_v[gi]);

            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    wr_ptr_reg <= '0;
                    rd_ptr_reg <= '0;
                    count_reg  <= '0;
                end else begin
                    if (push_v[gi]) begin
                        wr_ptr_reg <= (wr_ptr_reg == PtrW'(VCDepth - 1)) ? '0 : wr_ptr_reg + 1'b1;
                    end
                    if (pop_v[gi]) begin
                        rd_ptr_reg <= (rd_ptr_reg == PtrW'(VCDepth - 1)) ? '0 : rd_ptr_reg + 1'b1;
                    end
                    if (push_v[gi] && !pop_v[gi]) begin
                        count_reg <= count_reg + 1'b1;
                    end else if (!push_v[gi] && pop_v[gi]) begin
                        count_reg <= count_reg - 1'b1;
                    end
                end
            end

            always_ff @(posedge clk_i) begin
                if (push_v[gi]) begin
                    mem[wr_ptr_reg] <= {link.look_ahead, link.data};
                end
            end

            assign vc_valid[gi]  = (count_reg != '0);
            assign full[gi]      = (count_reg == CntW'(VCDepth));
            assign head_la[gi]   = mem[rd_ptr_reg][EntryW-1:DataWidth];
            assign head_data[gi] = mem[rd_ptr_reg][DataWidth-1:0];
        end
    endgenerate

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            credit_v_reg  <= 1'b0;
            credit_id_reg <= '0;
        end else begin
            credit_v_reg <= pop_eff;
            if (pop_eff) begin
                credit_id_reg <= pop_idx;
            end
        end
    end

    assign link.vc_valid      = vc_valid;
    assign link.vc_look_ahead = head_la;
    assign link.vc_data       = head_data;
    assign link.credit_v      = credit_v_reg;
    assign link.credit_id     = credit_id_reg;

`ifdef FLOO_VC_RX_ERR_EN
    logic err_reg;
    logic err_cond;

    // Multi-hot pop, pop of an empty VC, or a dropped flit (overflow / bad id).
    assign err_cond = ((link.pop & (link.pop - NumVC'(1))) != '0)
                      || ((link.pop & ~vc_valid) != '0)
                      || (link.valid && (push_v == '0));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_reg <= 1'b0;
        end else begin
            err_reg <= err_reg | err_cond;
        end
    end

    assign link.err = err_reg;
`else
    assign link.err = 1'b0;
`endif
endmodule

// File: tb/tb_floo_vc_input_port_rx.sv
// Directed bench for floo_vc_input_port_rx: stimulus queues expected pops/credits, a negedge monitor checks them.
module tb_floo_vc_input_port_rx;
    localparam int unsigned NumVC     = 4;
    localparam int unsigned VCDepth   = 2;
    localparam int unsigned DataWidth = 64;
    localparam int unsigned LaWidth   = 3;
`ifdef FLOO_VC_RX_ERR_EN
    localparam logic ErrEn = 1'b1;
`else
    localparam logic ErrEn = 1'b0;
`endif

    typedef struct {
        int          vc;
        logic [63:0] data;
        logic [2:0]  la;
        logic        valid;
    } pop_exp_t;

    logic clk = 1'b0;
    logic rst_ni = 1'b0;
    int   checks = 0;
    int   passes = 0;
    pop_exp_t pop_q[$];
    int       credit_q[$];

    always #5 clk = ~clk;

    floo_vc_input_port_rx_if #(.NumVC(NumVC), .DataWidth(DataWidth), .LaWidth(LaWidth)) link ();

    floo_vc_input_port_rx #(
        .NumVC(NumVC), .VCDepth(VCDepth), .DataWidth(DataWidth), .LaWidth(LaWidth)
    ) dut (
        .clk_i (clk),
        .rst_ni(rst_ni),
        .link  (link)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Scoreboard monitor: compares popped heads and returned credits against queued expectations.
    always @(negedge clk) begin
        pop_exp_t pe;
        int       exp_id;
        if (rst_ni && link.credit_v) begin
            if (credit_q.size() == 0) begin
                check("unexpected_credit", 64'(link.credit_id), 64'hFFFF);
            end else begin
                exp_id = credit_q.pop_front();
                $display("credit: id=%0d expected=%0d", link.credit_id, exp_id);
                check("credit_id", 64'(link.credit_id), 64'(exp_id));
            end
        end
        if (rst_ni && link.pop != '0) begin
            if (pop_q.size() == 0) begin
                check("unexpected_pop", 64'(link.pop), 64'h0);
            end else begin
                pe = pop_q.pop_front();
                $display("pop: mask=%b vc=%0d valid=%0b data=0x%0h la=%0d", link.pop, pe.vc,
                         link.vc_valid[pe.vc], link.vc_data[pe.vc], link.vc_look_ahead[pe.vc]);
                check("pop_head_valid", 64'(link.vc_valid[pe.vc]), 64'(pe.valid));
                if (pe.valid) begin
                    check("pop_head_data", link.vc_data[pe.vc], pe.data);
                    check("pop_head_la", 64'(link.vc_look_ahead[pe.vc]), 64'(pe.la));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        link.valid = 1'b0;
        link.pop   = '0;
    endtask

    task automatic set_push(input int vc, input logic [63:0] d, input logic [2:0] la);
        link.valid      = 1'b1;
        link.vc_id      = 2'(vc);
        link.data       = d;
        link.look_ahead = la;
    endtask

    task automatic set_pop(input logic [3:0] mask, input int vc, input logic exp_valid,
                           input logic [63:0] d, input logic [2:0] la, input logic credit);
        pop_exp_t pe;
        link.pop = mask;
        pe.vc = vc; pe.data = d; pe.la = la; pe.valid = exp_valid;
        pop_q.push_back(pe);
        if (credit) credit_q.push_back(vc);
    endtask

    task automatic push(input int vc, input logic [63:0] d, input logic [2:0] la);
        set_push(vc, d, la);
        tick();
        idle();
    endtask

    task automatic pop(input logic [3:0] mask, input int vc, input logic [63:0] d, input logic [2:0] la);
        set_pop(mask, vc, 1'b1, d, la, 1'b1);
        tick();
        idle();
    endtask

    task automatic do_reset();
        idle();
        rst_ni = 1'b0;
        tick();
        rst_ni = 1'b1;
        tick();
    endtask

    initial begin
        link.valid = 1'b0; link.vc_id = '0; link.look_ahead = '0; link.data = '0; link.pop = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_vc_valid", 64'(link.vc_valid), 64'h0);
        check("reset_credit_v", 64'(link.credit_v), 64'h0);
        check("reset_credit_id", 64'(link.credit_id), 64'h0);
        check("reset_err", 64'(link.err), 64'h0);
        rst_ni = 1'b1;
        tick();

        // T1: single flit on VC2, not visible before the clock edge.
        set_push(2, 64'hA5, 3'd3);
        check("t1_no_bypass", 64'(link.vc_valid), 64'h0);
        tick(); idle();
        check("t1_vc_valid", 64'(link.vc_valid), 64'h4);
        check("t1_head_data", link.vc_data[2], 64'hA5);
        check("t1_head_la", 64'(link.vc_look_ahead[2]), 64'd3);

        // T2: pop VC2, credit next cycle, then credit_v drops.
        pop(4'b0100, 2, 64'hA5, 3'd3);
        check("t2_vc_valid", 64'(link.vc_valid), 64'h0);
        tick();
        check("t2_credit_off", 64'(link.credit_v), 64'h0);

        // T3: overflow on VC1, FIFO order preserved.
        push(1, 64'h11, 3'd1);
        push(1, 64'h22, 3'd2);
        push(1, 64'h33, 3'd4);
        check("t3_vc_valid", 64'(link.vc_valid), 64'h2);
        check("t3_err", 64'(link.err), 64'(ErrEn));
        pop(4'b0010, 1, 64'h11, 3'd1);
        pop(4'b0010, 1, 64'h22, 3'd2);
        check("t3_drained", 64'(link.vc_valid), 64'h0);
        tick();

        rst_ni = 1'b0;
        #1;
        check("t3_reset_err", 64'(link.err), 64'h0);
        tick();
        rst_ni = 1'b1;
        tick();

        // T4: VC0 full, simultaneous push+pop keeps two entries and raises no error.
        push(0, 64'h40, 3'd0);
        push(0, 64'h41, 3'd1);
        set_push(0, 64'h42, 3'd2);
        set_pop(4'b0001, 0, 1'b1, 64'h40, 3'd0, 1'b1);
        tick(); idle();
        check("t4_vc_valid", 64'(link.vc_valid), 64'h1);
        check("t4_err", 64'(link.err), 64'h0);
        pop(4'b0001, 0, 64'h41, 3'd1);
        pop(4'b0001, 0, 64'h42, 3'd2);
        check("t4_drained", 64'(link.vc_valid), 64'h0);

        // T5: multi-hot pop picks the lowest VC only.
        push(1, 64'h51, 3'd5);
        push(3, 64'h53, 3'd6);
        pop(4'b1010, 1, 64'h51, 3'd5);
        check("t5_vc_valid", 64'(link.vc_valid), 64'h8);
        check("t5_err", 64'(link.err), 64'(ErrEn));
        pop(4'b1000, 3, 64'h53, 3'd6);
        tick();

        // Pop of an empty VC: ignored, no credit.
        do_reset();
        set_pop(4'b0001, 0, 1'b0, 64'h0, 3'd0, 1'b0);
        tick(); idle();
        check("empty_pop_err", 64'(link.err), 64'(ErrEn));
        tick();
        check("empty_pop_no_credit", 64'(link.credit_v), 64'h0);

        // T6: reset with VC3 full and a credit in flight.
        do_reset();
        push(3, 64'h61, 3'd1);
        push(3, 64'h62, 3'd2);
        set_push(3, 64'h63, 3'd3);
        set_pop(4'b1000, 3, 1'b1, 64'h61, 3'd1, 1'b0);
        tick(); idle();
        check("t6_credit_pending", 64'(link.credit_v), 64'h1);
        check("t6_vc3_full", 64'(link.vc_valid), 64'h8);
        rst_ni = 1'b0;
        #1;
        check("t6_rst_vc_valid", 64'(link.vc_valid), 64'h0);
        check("t6_rst_credit_v", 64'(link.credit_v), 64'h0);
        check("t6_rst_credit_id", 64'(link.credit_id), 64'h0);
        check("t6_rst_err", 64'(link.err), 64'h0);
        tick();
        rst_ni = 1'b1;
        tick();
        push(2, 64'hA5, 3'd3);
        check("t6_after_vc_valid", 64'(link.vc_valid), 64'h4);
        check("t6_after_data", link.vc_data[2], 64'hA5);
        pop(4'b0100, 2, 64'hA5, 3'd3);
        repeat (2) tick();

        check("credit_queue_empty", 64'(credit_q.size()), 64'h0);
        check("pop_queue_empty", 64'(pop_q.size()), 64'h0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
